// File: rtl/replication_arbiter_pkg.sv
// Shared operand widths and FSM state encoding for the replication arbiter.
package replication_arbiter_pkg;

  localparam int A_W = 1;
  localparam int B_W = 2;
  localparam int C_W = 2;
  localparam int Y_W = 7;

  // 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/replication_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the result consumer.
interface replication_arbiter_if #(
  parameter int CNT_W = 8
);
  import replication_arbiter_pkg::*;

  logic [1:0]       req_valid;
  logic [A_W-1:0]   req_a0;
  logic [A_W-1:0]   req_a1;
  logic [B_W-1:0]   req_b0;
  logic [B_W-1:0]   req_b1;
  logic [C_W-1:0]   req_c0;
  logic [C_W-1:0]   req_c1;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [Y_W-1:0]   rsp_y;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] xact_cnt;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_c0, req_c1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, busy, xact_cnt
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_c0, req_c1, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, busy, xact_cnt
  );

endinterface

// File: rtl/replication_arbiter_demo.sv
// Combinational replication datapath: y = {a, b, b, c}.
module replication_demo (
  input  logic [0:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic [6:0] y
);

  assign y = {a, {2{b}}, c};

endmodule

// File: rtl/replication_arbiter.sv
// Two-requester arbiter sharing one replication_demo datapath, with registered
// operands/result, valid/ready response handshake and a wrapping completion count.
module replication_arbiter #(
  parameter int CNT_W      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  replication_arbiter_if.slave bus
);
  import replication_arbiter_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             accept;
  logic             sel;
  logic [A_W-1:0]   op_a;
  logic [B_W-1:0]   op_b;
  logic [C_W-1:0]   op_c;
  logic [Y_W-1:0]   demo_y;
  logic             rsp_valid;
  logic [Y_W-1:0]   rsp_y;
  logic             rsp_id;
  logic [CNT_W-1:0] cnt;

  replication_demo u_demo (
    .a (op_a),
    .b (op_b),
    .c (op_c),
    .y (demo_y)
  );

  // One-hot grant; on a round-robin tie the requester that did not win last time goes.
  always_comb begin
    grant = '0;
    if (FIXED_PRIO) begin
      if (bus.req_valid[0])      grant = 2'b01;
      else if (bus.req_valid[1]) grant = 2'b10;
    end else if (bus.req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = bus.req_valid;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = '0;
    case (state)
      IDLE: begin
        ready = grant;
        if (|(bus.req_valid & grant)) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = |(bus.req_valid & ready);
  assign sel    = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a       <= sel ? bus.req_a1 : bus.req_a0;
        op_b       <= sel ? bus.req_b1 : bus.req_b0;
        op_c       <= sel ? bus.req_c1 : bus.req_c0;
        rsp_id     <= sel;
        last_grant <= sel;
      end
      if (state == EXEC) begin
        rsp_y     <= demo_y;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
        cnt       <= cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_id    = rsp_id;
  assign bus.busy      = (state != IDLE);
  assign bus.xact_cnt  = cnt;

endmodule
